vxu_issue_seq: RTL and testbench

Sequencer back end that drives the command port of the vector execution unit. It accepts decoded instruction records over a valid/ready handshake. Configuration records (vl, mod_q, mod_iq) become single-cycle writes. Compute records expand into a per-element beat stream with a running element counter. NTT records are throttled against the execution unit's reported count of outstanding NTT instructions.

---
 rtl/vxu_issue_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_vxu_issue_seq.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vxu_issue_seq.sv
// rtl/vxu_issue_seq.sv - issue sequencer driving the vector execution unit command port.
// Optional perf counters are enabled with VXU_ISSUE_SEQ_PERF_EN.
module vxu_issue_seq #(
  parameter int CNT_WIDTH   = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = 64,
  parameter int NTT_MAX_STD = 2,
  parameter int INST_GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_inst_vld,
  output logic                  o_inst_rdy,
  input  logic [1:0]            i_inst_cfg,
  input  logic [DATA_WIDTH-1:0] i_inst_scalar,
  input  logic [CTRL_WIDTH-1:0] i_inst_ctrl,
  input  logic [CNT_WIDTH:0]    i_inst_len,
  input  logic                  i_inst_is_ntt,
  input  logic [CNT_WIDTH:0]    i_ntt_inst_std_cnt,
  output logic                  o_op_vld,
  output logic [1:0]            o_op_cfg,
  output logic [DATA_WIDTH-1:0] o_scalar_cfg,
  output logic [CTRL_WIDTH-1:0] o_op_ctrl,
  output logic [CNT_WIDTH-1:0]  o_cnt,
  output logic                  o_comp_vld,
  output logic                  o_busy
`ifdef VXU_ISSUE_SEQ_PERF_EN
  ,
  output logic [31:0]           o_perf_busy_cyc,
  output logic [31:0]           o_perf_stall_cyc
`endif
);

  localparam int GAP_W = (INST_GAP > 1) ? $clog2(INST_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = (INST_GAP > 0) ? GAP_W'(INST_GAP - 1) : '0;
  localparam logic [CNT_WIDTH+1:0] MAX_STD = (CNT_WIDTH + 2)'(NTT_MAX_STD);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_GAP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cfg_q, cfg_d;
  logic [DATA_WIDTH-1:0]   scalar_q, scalar_d;
  logic [CTRL_WIDTH-1:0]   ctrl_q, ctrl_d;
  logic [CNT_WIDTH:0]      len_q, len_d;
  logic                    is_ntt_q, is_ntt_d;
  logic                    guard_q, guard_d;
  logic [CNT_WIDTH-1:0]    rem_q, rem_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    op_vld_q, op_vld_d;
  logic                    comp_vld_q, comp_vld_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [1:0]              op_cfg_q, op_cfg_d;
  logic [DATA_WIDTH-1:0]   scalar_out_q, scalar_out_d;
  logic [CTRL_WIDTH-1:0]   ctrl_out_q, ctrl_out_d;

  logic                    from_in;
  logic                    sel_ntt;
  logic [CNT_WIDTH+1:0]    std_sum;
  logic                    blocked;
  logic                    iss;
  logic [1:0]              iss_cfg;
  logic [DATA_WIDTH-1:0]   iss_scalar;
  logic [CTRL_WIDTH-1:0]   iss_ctrl;
  logic [CNT_WIDTH:0]      iss_len;
  logic                    iss_beats;

  // In IDLE the live record is judged; in WAIT the latched one is re-judged.
  assign from_in    = (state_q == S_IDLE);
  assign sel_ntt    = from_in ? i_inst_is_ntt : is_ntt_q;
  assign std_sum    = {1'b0, i_ntt_inst_std_cnt} + {{(CNT_WIDTH + 1){1'b0}}, guard_q};
  assign blocked    = sel_ntt && (std_sum >= MAX_STD);
  assign iss_cfg    = from_in ? i_inst_cfg    : cfg_q;
  assign iss_scalar = from_in ? i_inst_scalar : scalar_q;
  assign iss_ctrl   = from_in ? i_inst_ctrl   : ctrl_q;
  assign iss_len    = from_in ? i_inst_len    : len_q;
  assign iss_beats  = (iss_cfg == 2'b00) && (iss_len != '0);

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    scalar_d     = scalar_q;
    ctrl_d       = ctrl_q;
    len_d        = len_q;
    is_ntt_d     = is_ntt_q;
    guard_d      = op_vld_q && is_ntt_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    op_vld_d     = 1'b0;
    comp_vld_d   = 1'b0;
    cnt_d        = '0;
    op_cfg_d     = op_cfg_q;
    scalar_out_d = scalar_out_q;
    ctrl_out_d   = ctrl_out_q;
    iss          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_inst_vld) begin
          cfg_d    = i_inst_cfg;
          scalar_d = i_inst_scalar;
          ctrl_d   = i_inst_ctrl;
          len_d    = i_inst_len;
          is_ntt_d = i_inst_is_ntt;
          if (blocked) begin
            state_d = S_WAIT;
          end else begin
            iss = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!blocked) begin
          iss = 1'b1;
        end
      end
      S_RUN: begin
        if (rem_q != '0) begin
          rem_d      = rem_q - CNT_WIDTH'(1);
          cnt_d      = cnt_q + CNT_WIDTH'(1);
          comp_vld_d = 1'b1;
        end else if ((op_cfg_q != 2'b00) || (INST_GAP == 0)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_INIT;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Issue cycle carries beat 0; rem counts the beats still to follow it.
    if (iss) begin
      state_d      = S_RUN;
      op_vld_d     = 1'b1;
      cnt_d        = '0;
      comp_vld_d   = iss_beats;
      rem_d        = iss_beats ? CNT_WIDTH'(iss_len - (CNT_WIDTH + 1)'(1)) : '0;
      op_cfg_d     = iss_cfg;
      scalar_out_d = iss_scalar;
      ctrl_out_d   = iss_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cfg_q        <= '0;
      scalar_q     <= '0;
      ctrl_q       <= '0;
      len_q        <= '0;
      is_ntt_q     <= 1'b0;
      guard_q      <= 1'b0;
      rem_q        <= '0;
      gap_q        <= '0;
      op_vld_q     <= 1'b0;
      comp_vld_q   <= 1'b0;
      cnt_q        <= '0;
      op_cfg_q     <= '0;
      scalar_out_q <= '0;
      ctrl_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      scalar_q     <= scalar_d;
      ctrl_q       <= ctrl_d;
      len_q        <= len_d;
      is_ntt_q     <= is_ntt_d;
      guard_q      <= guard_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      op_vld_q     <= op_vld_d;
      comp_vld_q   <= comp_vld_d;
      cnt_q        <= cnt_d;
      op_cfg_q     <= op_cfg_d;
      scalar_out_q <= scalar_out_d;
      ctrl_out_q   <= ctrl_out_d;
    end
  end

  assign o_inst_rdy   = (state_q == S_IDLE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_op_vld     = op_vld_q;
  assign o_comp_vld   = comp_vld_q;
  assign o_cnt        = cnt_q;
  assign o_op_cfg     = op_cfg_q;
  assign o_scalar_cfg = scalar_out_q;
  assign o_op_ctrl    = ctrl_out_q;

`ifdef VXU_ISSUE_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if ((state_q != S_IDLE) && (perf_busy_q != '1)) begin
      perf_busy_d = perf_busy_q + 32'd1;
    end
    if ((state_q == S_WAIT) && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign o_perf_busy_cyc  = perf_busy_q;
  assign o_perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_vxu_issue_seq.sv
// tb/tb_vxu_issue_seq.sv - self-checking bench for vxu_issue_seq.
module tb_vxu_issue_seq;

  localparam int MAX_STD = 2;
  localparam int GAP     = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_inst_vld;
  logic [1:0]  i_inst_cfg;
  logic [63:0] i_inst_scalar;
  logic [63:0] i_inst_ctrl;
  logic [4:0]  i_inst_len;
  logic        i_inst_is_ntt;
  logic [4:0]  i_std;
  logic        o_inst_rdy, o_op_vld, o_comp_vld, o_busy;
  logic [1:0]  o_op_cfg;
  logic [63:0] o_scalar_cfg, o_op_ctrl;
  logic [3:0]  o_cnt;

  logic        vld2, ntt2;
  logic [4:0]  std2;
  logic        d2_rdy, d2_op_vld, d2_comp_vld, d2_busy;
  logic [1:0]  d2_cfg;
  logic [63:0] d2_scalar, d2_ctrl;
  logic [3:0]  d2_cnt;

`ifdef VXU_ISSUE_SEQ_PERF_EN
  logic [31:0] pb1, ps1, pb2, ps2;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  vxu_issue_seq dut (
    .clk(clk), .rst_n(rst_n), .i_inst_vld(i_inst_vld), .o_inst_rdy(o_inst_rdy),
    .i_inst_cfg(i_inst_cfg), .i_inst_scalar(i_inst_scalar), .i_inst_ctrl(i_inst_ctrl),
    .i_inst_len(i_inst_len), .i_inst_is_ntt(i_inst_is_ntt), .i_ntt_inst_std_cnt(i_std),
    .o_op_vld(o_op_vld), .o_op_cfg(o_op_cfg), .o_scalar_cfg(o_scalar_cfg),
    .o_op_ctrl(o_op_ctrl), .o_cnt(o_cnt), .o_comp_vld(o_comp_vld), .o_busy(o_busy)
`ifdef VXU_ISSUE_SEQ_PERF_EN
    , .o_perf_busy_cyc(pb1), .o_perf_stall_cyc(ps1)
`endif
  );

  vxu_issue_seq #(.INST_GAP(0), .NTT_MAX_STD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_inst_vld(vld2), .o_inst_rdy(d2_rdy),
    .i_inst_cfg(2'b00), .i_inst_scalar(i_inst_scalar), .i_inst_ctrl(i_inst_ctrl),
    .i_inst_len(5'd0), .i_inst_is_ntt(ntt2), .i_ntt_inst_std_cnt(std2),
    .o_op_vld(d2_op_vld), .o_op_cfg(d2_cfg), .o_scalar_cfg(d2_scalar),
    .o_op_ctrl(d2_ctrl), .o_cnt(d2_cnt), .o_comp_vld(d2_comp_vld), .o_busy(d2_busy)
`ifdef VXU_ISSUE_SEQ_PERF_EN
    , .o_perf_busy_cyc(pb2), .o_perf_stall_cyc(ps2)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each issued instruction becomes a queue of per-cycle expected outputs.
  typedef struct packed {
    logic       op_vld;
    logic       comp;
    logic [3:0] cnt;
    logic       ntt;
  } beat_t;

  beat_t       m_q[$];
  bit          m_wait, m_guard, m_busy, m_ng, e_busy;
  beat_t       m_cur, e_cur;
  logic [1:0]  m_cfg, e_cfg;
  logic [63:0] m_sc, m_ct, e_scalar, e_ctrl;
  int          m_len;
  bit          m_ntt;

  function automatic bit m_blocked(input bit ntt, input int std, input bit g);
    return ntt && ((std + int'(g)) >= MAX_STD);
  endfunction

  task automatic m_issue(input logic [1:0] c, input logic [63:0] s, input logic [63:0] t,
                         input int len, input bit ntt);
    beat_t b;
    int n;
    e_cfg = c;
    e_scalar = s;
    e_ctrl = t;
    if (c != 2'b00) begin
      b = '0;
      b.op_vld = 1'b1;
      b.ntt = ntt;
      m_q.push_back(b);
    end else begin
      n = (len == 0) ? 1 : len;
      for (int i = 0; i < n; i++) begin
        b.op_vld = (i == 0);
        b.comp = (len != 0);
        b.cnt = 4'(i % 16);
        b.ntt = ntt;
        m_q.push_back(b);
      end
      for (int i = 0; i < GAP; i++) m_q.push_back(beat_t'(0));
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_wait = 1'b0;
      m_guard = 1'b0;
      e_cfg = '0;
      e_scalar = '0;
      e_ctrl = '0;
    end else begin
      m_busy = (m_q.size() != 0) || m_wait;
      m_cur = (m_q.size() != 0) ? m_q[0] : beat_t'(0);
      m_ng = m_cur.op_vld && m_cur.ntt;
      if (m_q.size() != 0) void'(m_q.pop_front());
      if (!m_busy && i_inst_vld) begin
        m_cfg = i_inst_cfg;
        m_sc = i_inst_scalar;
        m_ct = i_inst_ctrl;
        m_len = int'(i_inst_len);
        m_ntt = i_inst_is_ntt;
        if (m_blocked(m_ntt, int'(i_std), m_guard)) m_wait = 1'b1;
        else m_issue(m_cfg, m_sc, m_ct, m_len, m_ntt);
      end else if (m_wait && !m_blocked(m_ntt, int'(i_std), m_guard)) begin
        m_wait = 1'b0;
        m_issue(m_cfg, m_sc, m_ct, m_len, m_ntt);
      end
      m_guard = m_ng;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_cur = (m_q.size() != 0) ? m_q[0] : beat_t'(0);
      e_busy = (m_q.size() != 0) || m_wait;
      chk("rdy", o_inst_rdy, !e_busy);
      chk("busy", o_busy, e_busy);
      chk("op_vld", o_op_vld, e_cur.op_vld);
      chk("comp_vld", o_comp_vld, e_cur.comp);
      chk("cnt", o_cnt, e_cur.cnt);
      chk("op_cfg", o_op_cfg, e_cfg);
      chk("scalar", o_scalar_cfg, e_scalar);
      chk("ctrl", o_op_ctrl, e_ctrl);
    end
  end

  task automatic send(input logic [1:0] c, input logic [63:0] s, input logic [63:0] t,
                      input logic [4:0] len, input logic ntt);
    int n;
    @(negedge clk);
    i_inst_cfg = c;
    i_inst_scalar = s;
    i_inst_ctrl = t;
    i_inst_len = len;
    i_inst_is_ntt = ntt;
    i_inst_vld = 1'b1;
    n = 0;
    while (!o_inst_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", (n >= 100), 1'b0);
    @(negedge clk);
    i_inst_vld = 1'b0;
  endtask

  task automatic run_out(output int busy_n, output int comp_n, output int op_n,
                         output logic [3:0] last_cnt);
    busy_n = 0;
    comp_n = 0;
    op_n = 0;
    last_cnt = '0;
    while (o_busy && busy_n < 200) begin
      busy_n++;
      if (o_comp_vld) begin
        comp_n++;
        last_cnt = o_cnt;
      end
      if (o_op_vld) op_n++;
      @(negedge clk);
    end
  endtask

  int         bn, cn, on;
  logic [3:0] lc;

  initial begin
    rst_n = 1'b0;
    i_inst_vld = 1'b0;
    i_inst_cfg = '0;
    i_inst_scalar = '0;
    i_inst_ctrl = '0;
    i_inst_len = '0;
    i_inst_is_ntt = 1'b0;
    i_std = '0;
    vld2 = 1'b0;
    ntt2 = 1'b0;
    std2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", o_inst_rdy, 1'b1);
    chk("rst_op_vld", o_op_vld, 1'b0);
    chk("rst_comp", o_comp_vld, 1'b0);
    chk("rst_cnt", o_cnt, 4'd0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ctrl", o_op_ctrl, 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Config write: issue one cycle after accept, ready again next cycle.
    send(2'b01, 64'h100, 64'h0, 5'd0, 1'b0);
    chk("cfg_op_vld", o_op_vld, 1'b1);
    chk("cfg_op_cfg", o_op_cfg, 2'b01);
    chk("cfg_scalar", o_scalar_cfg, 64'h100);
    chk("cfg_comp", o_comp_vld, 1'b0);
    @(negedge clk);
    chk("cfg_rdy_back", o_inst_rdy, 1'b1);

    // Compute len=4: four beats then two gap cycles.
    send(2'b00, 64'h0, 64'hABCD, 5'd4, 1'b0);
    chk("c4_cnt0", o_cnt, 4'd0);
    chk("c4_ctrl", o_op_ctrl, 64'hABCD);
    run_out(bn, cn, on, lc);
    chk("c4_busy_cycles", bn, 6);
    chk("c4_beats", cn, 4);
    chk("c4_last_cnt", lc, 4'd3);
    chk("c4_rdy", o_inst_rdy, 1'b1);

    // NTT stalled by outstanding count, released when it drops.
    i_std = 5'd2;
    send(2'b00, 64'h0, 64'h77, 5'd1, 1'b1);
    chk("ntt_wait_op_vld", o_op_vld, 1'b0);
    chk("ntt_wait_busy", o_busy, 1'b1);
    repeat (3) @(negedge clk);
    chk("ntt_still_wait", o_op_vld, 1'b0);
    i_std = 5'd1;
    @(negedge clk);
    chk("ntt_release", o_op_vld, 1'b1);
    run_out(bn, cn, on, lc);
    chk("ntt_busy_cycles", bn, 3);
    i_std = 5'd0;

    // Maximal length wraps the counter only at the last beat.
    send(2'b00, 64'h0, 64'h1616, 5'd16, 1'b0);
    run_out(bn, cn, on, lc);
    chk("c16_beats", cn, 16);
    chk("c16_last_cnt", lc, 4'd15);
    chk("c16_busy_cycles", bn, 18);

    send(2'b00, 64'h0, 64'h2, 5'd0, 1'b0);
    run_out(bn, cn, on, lc);
    chk("c0_beats", cn, 0);
    chk("c0_op_vld", on, 1);
    chk("c0_busy_cycles", bn, 3);

    // Back-to-back cfg with vld held: the record offered during issue is ignored.
    @(negedge clk);
    i_inst_cfg = 2'b10;
    i_inst_scalar = 64'h11;
    i_inst_vld = 1'b1;
    @(negedge clk);
    chk("b2b_first", o_scalar_cfg, 64'h11);
    i_inst_cfg = 2'b11;
    i_inst_scalar = 64'h22;
    @(negedge clk);
    chk("b2b_rdy", o_inst_rdy, 1'b1);
    i_inst_scalar = 64'h33;
    @(negedge clk);
    chk("b2b_second", o_scalar_cfg, 64'h33);
    chk("b2b_cfg", o_op_cfg, 2'b11);
    i_inst_vld = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a len=8 instruction.
    send(2'b00, 64'h0, 64'h5555, 5'd8, 1'b0);
    @(negedge clk);
    chk("mid_cnt1", o_cnt, 4'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_comp", o_comp_vld, 1'b0);
    chk("mid_rst_cnt", o_cnt, 4'd0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_rdy", o_inst_rdy, 1'b1);
    chk("mid_rst_ctrl", o_op_ctrl, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cn = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_comp_vld) cn++;
    end
    chk("mid_no_beats", cn, 0);

    // Guard: no-gap, max-1 instance; second NTT must stall the cycle after the first issue.
    @(negedge clk);
    vld2 = 1'b1;
    ntt2 = 1'b1;
    @(negedge clk);
    chk("g_first_issue", d2_op_vld, 1'b1);
    @(negedge clk);
    chk("g_rdy", d2_rdy, 1'b1);
    chk("g_idle_op", d2_op_vld, 1'b0);
    @(negedge clk);
    vld2 = 1'b0;
    std2 = 5'd1;
    chk("g_blocked_op", d2_op_vld, 1'b0);
    chk("g_blocked_busy", d2_busy, 1'b1);
    @(negedge clk);
    chk("g_wait_op", d2_op_vld, 1'b0);
    std2 = 5'd0;
    @(negedge clk);
    chk("g_second_issue", d2_op_vld, 1'b1);
    @(negedge clk);
    chk("g_rdy_end", d2_rdy, 1'b1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
